// File: rtl/srl_fifo_pkg.sv
// Shared sizing helpers and handshake event encoding for the SRL-based FIFO.
// Everything here is compile-time only; no logic is generated from the package.
// Both the interface and the RTL derive counter/address widths from it.
package srl_fifo_pkg;

  // Ceiling log2, with a minimum result of 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Occupancy counter width: must hold 0..DEPTH inclusive
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Storage address width: selects entries 0..DEPTH-1
  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  // Handshake events on one active edge, packed as {push, pop}
  typedef enum logic [1:0] {
    EV_IDLE = 2'b00,
    EV_POP  = 2'b01,
    EV_PUSH = 2'b10,
    EV_BOTH = 2'b11
  } ev_e;

endpackage

// File: rtl/srl_fifo_if.sv
// Handshake/data bundle of the SRL FIFO.
// master = producer/consumer environment, slave = the FIFO itself.
// WIDTH and DEPTH must match the parameters of the attached srl_fifo.
interface srl_fifo_if
  import srl_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] I_DATA;
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] O_DATA;
  logic             O_VALID;
  logic             O_READY;
  logic [CNT_W-1:0] COUNT;
  logic             FULL;
  logic             EMPTY;
  logic [WIDTH-1:0] LAST;

  modport master (
    output I_DATA, I_VALID, O_READY,
    input  I_READY, O_DATA, O_VALID, COUNT, FULL, EMPTY, LAST
  );

  modport slave (
    input  I_DATA, I_VALID, O_READY,
    output I_READY, O_DATA, O_VALID, COUNT, FULL, EMPTY, LAST
  );

endinterface

// File: rtl/srl_shift_array.sv
// Addressable shift register: shifts D in at entry 0 when CE, reads entry A.
// Latency: write visible the edge after CE; read is combinational from A.
// No backpressure and no reset: contents start at INIT_WORD and only move on CE.
module srl_shift_array
  import srl_fifo_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEPTH           = 32,
  parameter logic [WIDTH-1:0] INIT_WORD       = '0,
  parameter bit               IS_CLK_INVERTED = 1'b0,
  localparam int              ADDR_W          = addr_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              CE,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] A,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  LAST
);

  logic             clk_i;
  logic [WIDTH-1:0] r [DEPTH] = '{default: INIT_WORD};

  assign clk_i = IS_CLK_INVERTED ? ~CLK : CLK;

  // Shift the whole chain by one on enable; entry 0 takes the new word
  always_ff @(posedge clk_i) begin
    if (CE) begin
      r[0] <= D;
      for (int k = 1; k < DEPTH; k++) r[k] <= r[k-1];
    end
  end

  // Addresses past the last entry only occur for non-power-of-two depths
  assign Q    = (32'(A) < DEPTH) ? r[A] : '0;
  assign LAST = r[DEPTH-1];

endmodule

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO on a shift-register array addressed by occupancy.
// Latency: a word pushed into an empty FIFO is on O_DATA right after that edge.
// Backpressure: I_READY = !FULL from registered state only, independent of O_READY.
module srl_fifo
  import srl_fifo_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEPTH           = 32,
  parameter logic [WIDTH-1:0] INIT_WORD       = '0,
  parameter bit               IS_CLK_INVERTED = 1'b0
) (
  input  logic      CLK,
  input  logic      RST,
  srl_fifo_if.slave bus
);

  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int ADDR_W = addr_w(DEPTH);

  logic              clk_i;
  logic [CNT_W-1:0]  count;
  logic              full_q;
  logic              empty_q;
  logic              push;
  logic              pop;
  ev_e               ev;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  head;

  assign clk_i = IS_CLK_INVERTED ? ~CLK : CLK;

  // A full FIFO refuses pushes even when a pop frees a slot on the same edge
  assign push = bus.I_VALID & ~full_q;
  assign pop  = bus.O_READY & ~empty_q;
  assign ev   = ev_e'({push, pop});

  // Oldest word lives at entry count-1; the empty case is masked below
  assign rd_addr = ADDR_W'(count - 1'b1);

  srl_shift_array #(
    .WIDTH           (WIDTH),
    .DEPTH           (DEPTH),
    .INIT_WORD       (INIT_WORD),
    .IS_CLK_INVERTED (IS_CLK_INVERTED)
  ) u_array (
    .CLK  (CLK),
    .CE   (push),
    .D    (bus.I_DATA),
    .A    (rd_addr),
    .Q    (head),
    .LAST (bus.LAST)
  );

  // Occupancy and flags; storage is never cleared, reset only empties logically
  always_ff @(posedge clk_i or posedge RST) begin
    if (RST) begin
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      case (ev)
        EV_PUSH: begin
          count   <= count + 1'b1;
          full_q  <= (count == CNT_W'(DEPTH - 1));
          empty_q <= 1'b0;
        end
        EV_POP: begin
          count   <= count - 1'b1;
          full_q  <= 1'b0;
          empty_q <= (count == CNT_W'(1));
        end
        default: begin
          count   <= count;
          full_q  <= full_q;
          empty_q <= empty_q;
        end
      endcase
    end
  end

  assign bus.I_READY = ~full_q;
  assign bus.O_VALID = ~empty_q;
  assign bus.O_DATA  = empty_q ? '0 : head;
  assign bus.COUNT   = count;
  assign bus.FULL    = full_q;
  assign bus.EMPTY   = empty_q;

endmodule

// File: tb/tb_srl_fifo.sv
// Bench for srl_fifo: a 32-deep rising-edge instance and a 3-deep inverted-clock instance.
// Expected values come from queue models (FIFO contents plus push history for LAST).
// Directed steps from the test plan followed by randomized traffic on each instance.
module tb_srl_fifo;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  srl_fifo_if #(.WIDTH(8), .DEPTH(32)) bus_a ();
  srl_fifo_if #(.WIDTH(8), .DEPTH(3))  bus_b ();

  srl_fifo #(.WIDTH(8), .DEPTH(32), .INIT_WORD(8'h00), .IS_CLK_INVERTED(1'b0)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (bus_a.slave)
  );

  srl_fifo #(.WIDTH(8), .DEPTH(3), .INIT_WORD(8'h5A), .IS_CLK_INVERTED(1'b1)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (bus_b.slave)
  );

  // Reference state: queued words (oldest first) and most-recent-first push history
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ha[$];
  logic [7:0] hb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".a_count"}, 64'(bus_a.COUNT), 64'(qa.size()));
    chk({tag, ".a_empty"}, 64'(bus_a.EMPTY), 64'(qa.size() == 0));
    chk({tag, ".a_full"},  64'(bus_a.FULL),  64'(qa.size() == 32));
    chk({tag, ".a_ovld"},  64'(bus_a.O_VALID), 64'(qa.size() != 0));
    chk({tag, ".a_irdy"},  64'(bus_a.I_READY), 64'(qa.size() != 32));
    chk({tag, ".a_odata"}, 64'(bus_a.O_DATA), (qa.size() != 0) ? 64'(qa[0]) : 64'h0);
    chk({tag, ".a_last"},  64'(bus_a.LAST),  64'(ha[31]));
  endtask

  task automatic check_b(input string tag);
    chk({tag, ".b_count"}, 64'(bus_b.COUNT), 64'(qb.size()));
    chk({tag, ".b_empty"}, 64'(bus_b.EMPTY), 64'(qb.size() == 0));
    chk({tag, ".b_full"},  64'(bus_b.FULL),  64'(qb.size() == 3));
    chk({tag, ".b_irdy"},  64'(bus_b.I_READY), 64'(qb.size() != 3));
    chk({tag, ".b_odata"}, 64'(bus_b.O_DATA), (qb.size() != 0) ? 64'(qb[0]) : 64'h0);
    chk({tag, ".b_last"},  64'(bus_b.LAST),  64'(hb[2]));
  endtask

  // One rising-edge cycle on instance A; entered and left at posedge+1
  task automatic cyc_a(input string tag, input logic v, input logic [7:0] d, input logic r);
    logic do_push, do_pop;
    bus_a.I_VALID = v;
    bus_a.I_DATA  = d;
    bus_a.O_READY = r;
    do_push = v && (qa.size() < 32);
    do_pop  = r && (qa.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) void'(qa.pop_front());
    if (do_push) begin
      qa.push_back(d);
      ha.push_front(d);
      void'(ha.pop_back());
    end
    check_a(tag);
  endtask

  // One falling-edge cycle on instance B; entered and left at negedge+1.
  // State must not move on the intervening rising edge.
  task automatic cyc_b(input string tag, input logic v, input logic [7:0] d, input logic r);
    logic do_push, do_pop;
    bus_b.I_VALID = v;
    bus_b.I_DATA  = d;
    bus_b.O_READY = r;
    do_push = v && (qb.size() < 3);
    do_pop  = r && (qb.size() > 0);
    @(posedge clk);
    #1;
    chk({tag, ".b_pos_hold"}, 64'(bus_b.COUNT), 64'(qb.size()));
    @(negedge clk);
    #1;
    if (do_pop) void'(qb.pop_front());
    if (do_push) begin
      qb.push_back(d);
      hb.push_front(d);
      void'(hb.pop_back());
    end
    check_b(tag);
  endtask

  initial begin
    logic [7:0] dat;
    for (int i = 0; i < 32; i++) ha.push_back(8'h00);
    for (int i = 0; i < 3; i++) hb.push_back(8'h5A);
    rst = 1'b1;
    bus_a.I_VALID = 1'b0; bus_a.I_DATA = 8'h00; bus_a.O_READY = 1'b0;
    bus_b.I_VALID = 1'b0; bus_b.I_DATA = 8'h00; bus_b.O_READY = 1'b0;

    // Reset state while RST is held; B's LAST shows its power-up storage
    #2;
    check_a("reset");
    check_b("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_a("post_reset");

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) cyc_a("idle", 1'b0, 8'h00, 1'b0);

    // Three pushes held back, then three pops
    cyc_a("push3", 1'b1, 8'h11, 1'b0);
    cyc_a("push3", 1'b1, 8'h22, 1'b0);
    cyc_a("push3", 1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) cyc_a("pop3", 1'b0, 8'h00, 1'b1);

    // Fill to 32, 33rd push of 0xFF ignored, then drain in order
    for (int i = 0; i < 32; i++) cyc_a("fill", 1'b1, 8'(i), 1'b0);
    cyc_a("push_full", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 32; i++) cyc_a("drain", 1'b0, 8'h00, 1'b1);
    cyc_a("pop_empty", 1'b0, 8'h00, 1'b1);

    // Steady push+pop at COUNT=5 keeps occupancy and order
    for (int i = 0; i < 5; i++) cyc_a("to5", 1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 100; i++) cyc_a("both5", 1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 27; i++) cyc_a("to_full", 1'b1, 8'(8'h80 + i), 1'b0);
    cyc_a("both_full", 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 31; i++) cyc_a("drain2", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset pulse between edges, then a fresh push
    for (int i = 0; i < 4; i++) cyc_a("pre_rst", 1'b1, 8'(8'h40 + i), 1'b0);
    bus_a.I_VALID = 1'b0;
    bus_a.O_READY = 1'b0;
    #3 rst = 1'b1;
    #1;
    qa.delete();
    qb.delete();
    check_a("async_rst");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_a("after_rst");
    cyc_a("push_a5", 1'b1, 8'hA5, 1'b0);
    cyc_a("pop_a5", 1'b0, 8'h00, 1'b1);

    // Randomized traffic: push-heavy then pop-heavy, then balanced
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i < 200) ? 3 : ((i < 400) ? 1 : 2);
      cyc_a("rand_a", ($urandom_range(0, 3) < bias), 8'($urandom),
            ($urandom_range(0, 3) >= bias));
    end

    // Inverted-clock instance: realign to the falling edge
    @(negedge clk);
    #1;
    check_b("b_start");

    // Wrap: fill 3, pop 3, four times
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 3; i++) cyc_b("b_fill", 1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) cyc_b("b_pop", 1'b0, 8'h00, 1'b1);
    end

    // Full boundary: blocked push, push+pop at full, push+pop at COUNT=1
    for (int i = 0; i < 3; i++) cyc_b("b_fill2", 1'b1, 8'(8'h60 + i), 1'b0);
    cyc_b("b_push_full", 1'b1, 8'hFF, 1'b0);
    cyc_b("b_both_full", 1'b1, 8'hFE, 1'b1);
    cyc_b("b_pop", 1'b0, 8'h00, 1'b1);
    cyc_b("b_both_one", 1'b1, 8'h77, 1'b1);
    cyc_b("b_pop_last", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 300; i++) begin
      dat = 8'($urandom);
      cyc_b("rand_b", $urandom_range(0, 1) == 1, dat, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
